hyper_txn_sequencer: RTL and testbench
======================================

Name: hyper_txn_sequencer

Overview:
- Sequences single HyperBus transactions (CA phase, initial latency, data burst, CS# recovery) toward an s27ks0641-class HyperRAM.
- Sits between the AXI-side transaction front end and the DDR I/O register stage that owns the pads.
- Works at SDR on clk_i: one 16-bit word per cycle, with {rising byte, falling byte} = {[15:8],[7:0]}.
- The DDR stage converts words to pad DQ/RWDS and gates CK/CK# from ck_en_o.

Parameters:
- LATENCY, 6, initial latency in clk_i cycles for 1x latency; 2x doubles it.
- CS_HIGH, 2, minimum cycles cs_n_o stays high between transactions (tCSHI).
- RX_TIMEOUT, 64, maximum cycles without rx_valid_i during a read data phase before abort.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; synchronous, active-high.
- req_valid_i  in  1  transaction request valid.
- req_ready_o  out  1  request accepted when valid&ready.
- req_write_i  in  1  1=write, 0=read.
- req_addr_i  in  32  half-word address.
- req_len_i  in  8  burst length in words minus 1.
- wdata_valid_i  in  1  write word valid.
- wdata_i  in  16  write word.
- wdata_ready_o  out  1  write word consumed.
- rdata_valid_o  out  1  read word valid (no backpressure).
- rdata_o  out  16  read word.
- done_o  out  1  one-cycle transaction completion pulse.
- err_o  out  1  qualifies done_o: read timeout.
- cs_n_o  out  1  chip select, active-low.
- ck_en_o  out  1  CK toggle enable for this cycle.
- dq_o  out  16  DQ word to DDR stage.
- dq_oe_o  out  1  DQ output enable.
- rwds_o  out  2  write byte mask per half-word, 1=masked.
- rwds_oe_o  out  1  RWDS output enable.
- rwds_lat_i  in  1  RWDS level sampled by the DDR stage during CA.
- rx_valid_i  in  1  read word strobed by RWDS, resynchronised.
- rx_data_i  in  16  read word.

Behaviour:
- Reset values:
  - cs_n_o=1; ck_en_o, dq_oe_o, rwds_oe_o, req_ready_o, wdata_ready_o, rdata_valid_o, done_o, err_o=0.
  - dq_o=0, rwds_o=0.
  - State=CSHI, CS counter loaded with CS_HIGH.
- FSM states: IDLE, CA, LAT, WDATA, RDATA, CSHI.
- IDLE:
  - req_ready_o=1.
  - On valid&ready, latch write, addr, len; go to CA.
- CA (3 cycles):
  - cs_n_o=0, ck_en_o=1, dq_oe_o=1.
  - CA[47:0] is built as: [47]=~write, [46]=0 (memory space), [45]=1 (linear), [44:16]=addr[31:3], [15:3]=0, [2:0]=addr[2:0].
  - dq_o carries CA[47:32], then CA[31:16], then CA[15:0].
  - rwds_lat_i is sampled in CA cycle 1 (the first): 1 selects 2*LATENCY, 0 selects LATENCY.
- LAT:
  - Exactly N cycles with cs_n_o=0, ck_en_o=1, dq_oe_o=0, rwds_oe_o=0.
  - Then go to WDATA if write, else RDATA.
- WDATA:
  - dq_oe_o=1, rwds_oe_o=1, rwds_o=2'b00, wdata_ready_o=1.
  - On wdata_valid_i: dq_o=wdata_i, ck_en_o=1, and the word counter increments.
  - On !wdata_valid_i: ck_en_o=0, CS stays low, and the outputs hold (clock-stop stall).
  - After len+1 accepted words, go to CSHI.
- RDATA:
  - ck_en_o=1 and dq_oe_o=0.
  - Each rx_valid_i produces rdata_valid_o=1 and rdata_o=rx_data_i in the same cycle (combinational pass-through, zero latency).
  - The idle counter resets on each rx_valid_i.
  - After len+1 words, go to CSHI.
  - If RX_TIMEOUT consecutive cycles pass without rx_valid_i, set err_o and go to CSHI.
- CSHI:
  - cs_n_o=1, ck_en_o=0, dq_oe_o=0.
  - Entry from a transaction: done_o=1 for the first cycle, with err_o set only if aborted.
  - Stay for CS_HIGH cycles, then go to IDLE.
  - rx_valid_i is ignored here; late words are dropped.
- Counters:
  - Word counter is 9 bits, so len=255 gives 256 words with no wrap.
  - Latency counter covers 2*LATENCY.
- Address wrap: not handled; linear bursts crossing the device end are the requester's responsibility.
- Simultaneous events: req_valid_i is ignored outside IDLE, and no new request is accepted in the done_o cycle.
- rst_i mid-transaction: synchronous return to reset values. cs_n_o rises on the next edge, no done_o is emitted, and partial data is discarded.
- No burst-length limit for tCSM is enforced here; the front end splits bursts.

Test Plan:
- Read, addr=0x0000_1235, len=3, rwds_lat_i=0, rx words 0xA001..0xA004: CA words 0xA000/0x0246/0x0005, then 6 LAT cycles, 4 rdata_valid_o, done_o=1, err_o=0, cs_n_o high for 2 cycles.
- Write, addr=0x10, len=1, rwds_lat_i=1, wdata 0xBEEF, 0xCAFE: CA[47]=0, 12 LAT cycles, dq_o=0xBEEF then 0xCAFE with rwds_oe_o=1 and rwds_o=00, then done_o.
- Write with wdata_valid_i low 3 cycles mid-burst: ck_en_o=0 for those 3 cycles, cs_n_o stays 0, burst completes with correct word count.
- Read with only 2 of 4 rx words then silence: done_o with err_o=1 exactly RX_TIMEOUT cycles after the last word, and cs_n_o rises.
- Back-to-back requests held valid: second req_ready_o not before CS_HIGH cycles of cs_n_o=1 after the first done_o.
- rst_i asserted during LAT: next cycle cs_n_o=1, req_ready_o=0, no done_o; after CS_HIGH cycles IDLE accepts a new request.

Source files
------------

// File: rtl/hyper_txn_if.sv
// rtl/hyper_txn_if.sv - request, write-data, read-data and HyperBus pad-side signals of the transaction sequencer
interface hyper_txn_if;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_write_i;
    logic [31:0] req_addr_i;
    logic [7:0]  req_len_i;
    logic        wdata_valid_i;
    logic [15:0] wdata_i;
    logic        wdata_ready_o;
    logic        rdata_valid_o;
    logic [15:0] rdata_o;
    logic        done_o;
    logic        err_o;
    logic        cs_n_o;
    logic        ck_en_o;
    logic [15:0] dq_o;
    logic        dq_oe_o;
    logic [1:0]  rwds_o;
    logic        rwds_oe_o;
    logic        rwds_lat_i;
    logic        rx_valid_i;
    logic [15:0] rx_data_i;

    // Sequencer side
    modport slave (
        input  req_valid_i, req_write_i, req_addr_i, req_len_i,
        input  wdata_valid_i, wdata_i, rwds_lat_i, rx_valid_i, rx_data_i,
        output req_ready_o, wdata_ready_o, rdata_valid_o, rdata_o,
        output done_o, err_o, cs_n_o, ck_en_o, dq_o, dq_oe_o, rwds_o, rwds_oe_o
    );

    // Front end / DDR stage side
    modport master (
        output req_valid_i, req_write_i, req_addr_i, req_len_i,
        output wdata_valid_i, wdata_i, rwds_lat_i, rx_valid_i, rx_data_i,
        input  req_ready_o, wdata_ready_o, rdata_valid_o, rdata_o,
        input  done_o, err_o, cs_n_o, ck_en_o, dq_o, dq_oe_o, rwds_o, rwds_oe_o
    );
endinterface

// File: rtl/hyper_txn_sequencer.sv
// rtl/hyper_txn_sequencer.sv - single HyperBus transaction sequencer (CA, latency, burst, CS# recovery)
module hyper_txn_sequencer #(
    parameter int LATENCY    = 6,
    parameter int CS_HIGH    = 2,
    parameter int RX_TIMEOUT = 64
) (
    input  logic         clk_i,
    input  logic         rst_i,
    hyper_txn_if.slave   bus
);

    localparam int LAT_W  = $clog2(2 * LATENCY + 1);
    localparam int CS_W   = $clog2(CS_HIGH + 1);
    localparam int IDLE_W = $clog2(RX_TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CA,
        S_LAT,
        S_WDATA,
        S_RDATA,
        S_CSHI
    } state_t;

    state_t             state;
    logic               write_q;
    logic [31:0]        addr_q;
    logic [7:0]         len_q;
    logic               lat2x_q;
    logic [1:0]         ca_cnt;
    logic [LAT_W-1:0]   lat_cnt;
    logic [8:0]         word_cnt;
    logic [IDLE_W-1:0]  idle_cnt;
    logic [CS_W-1:0]    cs_cnt;

    logic               cs_n_q;
    logic               ck_en_q;
    logic               dq_oe_q;
    logic               rwds_oe_q;
    logic               req_ready_q;
    logic               wdata_ready_q;
    logic               done_q;
    logic               err_q;
    logic [15:0]        dq_q;

    // Command/address word idx of the 48-bit CA: read flag, memory space, linear burst, split address
    function automatic logic [15:0] ca_word(input logic w, input logic [31:0] a, input logic [1:0] idx);
        logic [47:0] ca;
        ca = {~w, 1'b0, 1'b1, a[31:3], 13'd0, a[2:0]};
        case (idx)
            2'd0:    return ca[47:32];
            2'd1:    return ca[31:16];
            default: return ca[15:0];
        endcase
    endfunction

    // Transaction FSM; control outputs are set on the transition into each state
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state         <= S_CSHI;
            cs_cnt        <= CS_W'(CS_HIGH);
            write_q       <= 1'b0;
            addr_q        <= '0;
            len_q         <= '0;
            lat2x_q       <= 1'b0;
            ca_cnt        <= '0;
            lat_cnt       <= '0;
            word_cnt      <= '0;
            idle_cnt      <= '0;
            cs_n_q        <= 1'b1;
            ck_en_q       <= 1'b0;
            dq_oe_q       <= 1'b0;
            rwds_oe_q     <= 1'b0;
            req_ready_q   <= 1'b0;
            wdata_ready_q <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            dq_q          <= '0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.req_valid_i) begin
                        write_q     <= bus.req_write_i;
                        addr_q      <= bus.req_addr_i;
                        len_q       <= bus.req_len_i;
                        ca_cnt      <= '0;
                        req_ready_q <= 1'b0;
                        cs_n_q      <= 1'b0;
                        ck_en_q     <= 1'b1;
                        dq_oe_q     <= 1'b1;
                        dq_q        <= ca_word(bus.req_write_i, bus.req_addr_i, 2'd0);
                        state       <= S_CA;
                    end
                end
                S_CA: begin
                    // The device drives its latency indication on RWDS during the first CA beat
                    if (ca_cnt == 2'd0) begin
                        lat2x_q <= bus.rwds_lat_i;
                    end
                    if (ca_cnt == 2'd2) begin
                        lat_cnt <= lat2x_q ? LAT_W'(2 * LATENCY) : LAT_W'(LATENCY);
                        dq_oe_q <= 1'b0;
                        dq_q    <= '0;
                        state   <= S_LAT;
                    end else begin
                        ca_cnt <= ca_cnt + 2'd1;
                        dq_q   <= ca_word(write_q, addr_q, ca_cnt + 2'd1);
                    end
                end
                S_LAT: begin
                    if (lat_cnt == LAT_W'(1)) begin
                        word_cnt <= '0;
                        idle_cnt <= '0;
                        if (write_q) begin
                            dq_oe_q       <= 1'b1;
                            rwds_oe_q     <= 1'b1;
                            wdata_ready_q <= 1'b1;
                            ck_en_q       <= 1'b0;
                            state         <= S_WDATA;
                        end else begin
                            state <= S_RDATA;
                        end
                    end else begin
                        lat_cnt <= lat_cnt - LAT_W'(1);
                    end
                end
                S_WDATA: begin
                    if (bus.wdata_valid_i) begin
                        word_cnt <= word_cnt + 9'd1;
                        if (word_cnt == {1'b0, len_q}) begin
                            cs_n_q        <= 1'b1;
                            dq_oe_q       <= 1'b0;
                            rwds_oe_q     <= 1'b0;
                            wdata_ready_q <= 1'b0;
                            dq_q          <= '0;
                            done_q        <= 1'b1;
                            cs_cnt        <= CS_W'(CS_HIGH);
                            state         <= S_CSHI;
                        end else begin
                            dq_q <= bus.wdata_i;
                        end
                    end
                end
                S_RDATA: begin
                    if (bus.rx_valid_i) begin
                        idle_cnt <= '0;
                        word_cnt <= word_cnt + 9'd1;
                        if (word_cnt == {1'b0, len_q}) begin
                            cs_n_q  <= 1'b1;
                            ck_en_q <= 1'b0;
                            done_q  <= 1'b1;
                            cs_cnt  <= CS_W'(CS_HIGH);
                            state   <= S_CSHI;
                        end
                    end else if (idle_cnt == IDLE_W'(RX_TIMEOUT - 2)) begin
                        // done_o with err_o lands RX_TIMEOUT cycles after the last received word
                        cs_n_q  <= 1'b1;
                        ck_en_q <= 1'b0;
                        done_q  <= 1'b1;
                        err_q   <= 1'b1;
                        cs_cnt  <= CS_W'(CS_HIGH);
                        state   <= S_CSHI;
                    end else begin
                        idle_cnt <= idle_cnt + IDLE_W'(1);
                    end
                end
                S_CSHI: begin
                    if (cs_cnt == CS_W'(1)) begin
                        req_ready_q <= 1'b1;
                        state       <= S_IDLE;
                    end else begin
                        cs_cnt <= cs_cnt - CS_W'(1);
                    end
                end
                default: begin
                    state <= S_CSHI;
                    cs_cnt <= CS_W'(CS_HIGH);
                end
            endcase
        end
    end

    // Write words go straight to the pads when offered; a missing word stops CK and holds DQ
    assign bus.ck_en_o       = (state == S_WDATA) ? bus.wdata_valid_i : ck_en_q;
    assign bus.dq_o          = (state == S_WDATA && bus.wdata_valid_i) ? bus.wdata_i : dq_q;
    assign bus.rdata_valid_o = (state == S_RDATA) && bus.rx_valid_i;
    assign bus.rdata_o       = bus.rdata_valid_o ? bus.rx_data_i : 16'h0000;
    assign bus.rwds_o        = 2'b00;
    assign bus.cs_n_o        = cs_n_q;
    assign bus.dq_oe_o       = dq_oe_q;
    assign bus.rwds_oe_o     = rwds_oe_q;
    assign bus.req_ready_o   = req_ready_q;
    assign bus.wdata_ready_o = wdata_ready_q;
    assign bus.done_o        = done_q;
    assign bus.err_o         = err_q;

endmodule

// File: tb/tb_hyper_txn_sequencer.sv
// tb/tb_hyper_txn_sequencer.sv - table-driven and randomized bench for hyper_txn_sequencer
module tb_hyper_txn_sequencer;

    localparam int LATENCY    = 6;
    localparam int CS_HIGH    = 2;
    localparam int RX_TIMEOUT = 64;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hyper_txn_if bus();

    hyper_txn_sequencer #(
        .LATENCY   (LATENCY),
        .CS_HIGH   (CS_HIGH),
        .RX_TIMEOUT(RX_TIMEOUT)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    typedef struct {
        bit          w;
        logic [31:0] addr;
        int          len;
        bit          lat2x;
        int          n_deliver;
        logic [15:0] w0;
        logic [15:0] w1;
        int          stall_idx;
        int          stall_len;
        logic [47:0] exp_ca;
        int          exp_lat;
        bit          exp_err;
    } vec_t;

    int          vec_cnt  = 0;
    int          miss_cnt = 0;
    int          last_wait;
    logic [15:0] words[$];
    vec_t        tbl[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [47:0] model_ca(input bit w, input logic [31:0] a);
        logic [47:0] r;
        r = 48'h2000_0000_0000;
        if (!w) r = r + 48'h8000_0000_0000;
        r = r + 48'(a / 8) * 48'h1_0000;
        r = r + 48'(a % 8);
        return r;
    endfunction

    task automatic idle_inputs();
        bus.req_valid_i   = 1'b0;
        bus.wdata_valid_i = 1'b0;
        bus.rx_valid_i    = 1'b0;
        bus.rwds_lat_i    = 1'b0;
    endtask

    task automatic request(input bit w, input logic [31:0] a, input int len, output bit got);
        got = 1'b0;
        last_wait = 0;
        while (!got && last_wait < 20) begin
            @(negedge clk);
            bus.req_valid_i   = 1'b1;
            bus.req_write_i   = w;
            bus.req_addr_i    = a;
            bus.req_len_i     = 8'(len);
            bus.wdata_valid_i = 1'b0;
            bus.rx_valid_i    = 1'b0;
            #1;
            if (bus.req_ready_o === 1'b1) got = 1'b1;
            else last_wait++;
        end
        chk("req_ready", 32'(got), 32'd1);
        if (got) chk("cs_n_idle", 32'(bus.cs_n_o), 32'd1);
    endtask

    task automatic run_txn(input bit w, input logic [31:0] a, input int len, input bit lat2x,
                           input int n_deliver, input logic [47:0] exp_ca, input int exp_lat,
                           input bit exp_err, input bit rand_gaps, input int stall_idx, input int stall_len);
        bit          got;
        logic [15:0] prev;
        bit          have;
        int          n;
        request(w, a, len, got);
        if (!got) return;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            bus.req_valid_i = 1'b0;
            bus.req_addr_i  = $urandom;
            bus.req_write_i = ~w;
            bus.rwds_lat_i  = (k == 0) ? lat2x : ~lat2x;
            #1;
            chk("ca_word", 32'(bus.dq_o), 32'(exp_ca[47 - 16 * k -: 16]));
            chk("ca_cs_n", 32'(bus.cs_n_o), 32'd0);
            chk("ca_ck_en", 32'(bus.ck_en_o), 32'd1);
            chk("ca_dq_oe", 32'(bus.dq_oe_o), 32'd1);
        end
        for (int j = 0; j < exp_lat; j++) begin
            @(negedge clk);
            bus.rwds_lat_i = 1'b0;
            #1;
            chk("lat_cs_n", 32'(bus.cs_n_o), 32'd0);
            chk("lat_ck_en", 32'(bus.ck_en_o), 32'd1);
            chk("lat_oe", {30'd0, bus.dq_oe_o, bus.rwds_oe_o}, 32'd0);
            chk("lat_rdv", 32'(bus.rdata_valid_o), 32'd0);
        end
        if (w) begin
            prev = 16'h0;
            have = 1'b0;
            for (int i = 0; i <= len; i++) begin
                n = (i == stall_idx) ? stall_len : (rand_gaps ? int'($urandom_range(0, 2)) : 0);
                for (int s = 0; s < n; s++) begin
                    @(negedge clk);
                    bus.wdata_valid_i = 1'b0;
                    bus.wdata_i       = 16'($urandom);
                    #1;
                    chk("stall_ck_en", 32'(bus.ck_en_o), 32'd0);
                    chk("stall_cs_n", 32'(bus.cs_n_o), 32'd0);
                    chk("stall_ready", 32'(bus.wdata_ready_o), 32'd1);
                    chk("stall_oe", {30'd0, bus.dq_oe_o, bus.rwds_oe_o}, 32'd3);
                    if (have) chk("stall_hold", 32'(bus.dq_o), 32'(prev));
                end
                @(negedge clk);
                bus.wdata_valid_i = 1'b1;
                bus.wdata_i       = words[i];
                #1;
                chk("wr_dq", 32'(bus.dq_o), 32'(words[i]));
                chk("wr_ck_en", 32'(bus.ck_en_o), 32'd1);
                chk("wr_ready", 32'(bus.wdata_ready_o), 32'd1);
                chk("wr_rwds", {29'd0, bus.rwds_oe_o, bus.rwds_o}, 32'd4);
                chk("wr_cs_n", 32'(bus.cs_n_o), 32'd0);
                prev = words[i];
                have = 1'b1;
            end
        end else begin
            for (int i = 0; i < n_deliver; i++) begin
                n = rand_gaps ? int'($urandom_range(0, 3)) : 0;
                for (int s = 0; s < n; s++) begin
                    @(negedge clk);
                    bus.rx_valid_i = 1'b0;
                    #1;
                    chk("rd_gap_rdv", 32'(bus.rdata_valid_o), 32'd0);
                    chk("rd_gap_cs_n", 32'(bus.cs_n_o), 32'd0);
                    chk("rd_gap_ck", {30'd0, bus.ck_en_o, bus.dq_oe_o}, 32'd2);
                end
                @(negedge clk);
                bus.rx_valid_i = 1'b1;
                bus.rx_data_i  = words[i];
                #1;
                chk("rd_valid", 32'(bus.rdata_valid_o), 32'd1);
                chk("rd_data", 32'(bus.rdata_o), 32'(words[i]));
                chk("rd_cs_n", 32'(bus.cs_n_o), 32'd0);
            end
            if (n_deliver < len + 1) begin
                for (int j = 1; j < RX_TIMEOUT; j++) begin
                    @(negedge clk);
                    bus.rx_valid_i = 1'b0;
                    #1;
                    chk("to_wait_done", 32'(bus.done_o), 32'd0);
                    chk("to_wait_cs_n", 32'(bus.cs_n_o), 32'd0);
                end
            end
        end
        @(negedge clk);
        bus.wdata_valid_i = 1'b0;
        bus.rx_valid_i    = 1'b1;
        bus.rx_data_i     = 16'hDEAD;
        bus.req_valid_i   = 1'b1;
        bus.req_addr_i    = $urandom;
        #1;
        chk("done", 32'(bus.done_o), 32'd1);
        chk("err", 32'(bus.err_o), 32'(exp_err));
        chk("cshi_cs_n", 32'(bus.cs_n_o), 32'd1);
        chk("cshi_ck_oe", {30'd0, bus.ck_en_o, bus.dq_oe_o}, 32'd0);
        chk("cshi_ready", 32'(bus.req_ready_o), 32'd0);
        chk("cshi_late_rx", 32'(bus.rdata_valid_o), 32'd0);
        for (int j = 1; j < CS_HIGH; j++) begin
            @(negedge clk);
            bus.rx_valid_i = 1'b0;
            #1;
            chk("cshi_hold_cs_n", 32'(bus.cs_n_o), 32'd1);
            chk("cshi_hold_ready", 32'(bus.req_ready_o), 32'd0);
            chk("cshi_hold_done", 32'(bus.done_o), 32'd0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          w;
        bit          got;
        bit          l2;
        logic [31:0] a;
        int          len;
        int          nd;

        tbl[0] = '{1'b0, 32'h0000_1235, 3,   1'b0, 4, 16'hA001, 16'hA002, -1, 0, 48'hA000_0246_0005, 6,  1'b0};
        tbl[1] = '{1'b1, 32'h0000_0010, 1,   1'b1, 0, 16'hBEEF, 16'hCAFE, -1, 0, 48'h2000_0002_0000, 12, 1'b0};
        tbl[2] = '{1'b1, 32'h0000_0040, 3,   1'b0, 0, 16'h1111, 16'h2222, 2,  3, 48'h2000_0008_0000, 6,  1'b0};
        tbl[3] = '{1'b0, 32'h0000_0007, 3,   1'b0, 2, 16'hC001, 16'hC002, -1, 0, 48'hA000_0000_0007, 6,  1'b1};
        tbl[4] = '{1'b0, 32'hFFFF_FFFF, 0,   1'b1, 1, 16'h5A5A, 16'h0000, -1, 0, 48'hBFFF_FFFF_0007, 12, 1'b0};
        tbl[5] = '{1'b1, 32'h0000_0000, 255, 1'b0, 0, 16'h0000, 16'h0001, -1, 0, 48'h2000_0000_0000, 6,  1'b0};

        rst = 1'b1;
        idle_inputs();
        bus.req_write_i = 1'b0;
        bus.req_addr_i  = '0;
        bus.req_len_i   = '0;
        bus.wdata_i     = '0;
        bus.rx_data_i   = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_cs_n", 32'(bus.cs_n_o), 32'd1);
        chk("rst_enables", {27'd0, bus.ck_en_o, bus.dq_oe_o, bus.rwds_oe_o, bus.req_ready_o, bus.wdata_ready_o}, 32'd0);
        chk("rst_status", {29'd0, bus.rdata_valid_o, bus.done_o, bus.err_o}, 32'd0);
        chk("rst_dq", 32'(bus.dq_o), 32'd0);
        chk("rst_rwds", 32'(bus.rwds_o), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int v = 0; v < 6; v++) begin
            words.delete();
            for (int i = 0; i <= tbl[v].len; i++)
                words.push_back(i == 0 ? tbl[v].w0 : tbl[v].w1 + 16'(i - 1));
            run_txn(tbl[v].w, tbl[v].addr, tbl[v].len, tbl[v].lat2x, tbl[v].n_deliver, tbl[v].exp_ca,
                    tbl[v].exp_lat, tbl[v].exp_err, 1'b0, tbl[v].stall_idx, tbl[v].stall_len);
        end

        // Back-to-back: request held valid through CS# recovery is taken on the first IDLE cycle
        words.delete();
        words.push_back(16'h0101);
        run_txn(1'b1, 32'h0000_0100, 0, 1'b0, 0, model_ca(1'b1, 32'h100), LATENCY, 1'b0, 1'b0, -1, 0);
        chk("b2b_wait", 32'(last_wait), 32'd0);

        // Reset in the middle of the latency phase
        request(1'b1, 32'h0000_0020, 0, got);
        repeat (5) begin
            @(negedge clk);
            idle_inputs();
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_rst_cs_n", 32'(bus.cs_n_o), 32'd1);
        chk("mid_rst_ready", 32'(bus.req_ready_o), 32'd0);
        chk("mid_rst_done", 32'(bus.done_o), 32'd0);
        chk("mid_rst_ck_oe", {30'd0, bus.ck_en_o, bus.dq_oe_o}, 32'd0);
        @(negedge clk);
        #1;
        chk("mid_rst_ready2", 32'(bus.req_ready_o), 32'd0);
        chk("mid_rst_done2", 32'(bus.done_o), 32'd0);
        @(negedge clk);
        #1;
        chk("mid_rst_idle", 32'(bus.req_ready_o), 32'd1);
        words.delete();
        words.push_back(16'h7E57);
        run_txn(1'b0, 32'h0000_0033, 0, 1'b0, 1, model_ca(1'b0, 32'h33), LATENCY, 1'b0, 1'b0, -1, 0);

        // Randomized transactions against the behavioural model
        for (int t = 0; t < 30; t++) begin
            w   = 1'($urandom_range(0, 1));
            a   = $urandom;
            l2  = 1'($urandom_range(0, 1));
            len = ($urandom_range(0, 7) == 0) ? int'($urandom_range(8, 40)) : int'($urandom_range(0, 4));
            nd  = len + 1;
            if (!w && len > 0 && $urandom_range(0, 5) == 0) nd = int'($urandom_range(1, len));
            words.delete();
            for (int i = 0; i <= len; i++) words.push_back(16'($urandom));
            run_txn(w, a, len, l2, w ? 0 : nd, model_ca(w, a), l2 ? 2 * LATENCY : LATENCY,
                    (!w && nd < len + 1), 1'b1, -1, 0);
        end

        @(negedge clk);
        idle_inputs();
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
